// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter: shifts STEP bits per cycle until done.
// Define ITERATIVE_SHIFTER_ROTATE_EN to make op 11 a rotate-left (else SLL).
module iterative_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // STEP may equal WIDTH, so compare in one extra bit
   localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
   localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [1:0]         op_q, op_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;

   logic [SHAMT_W:0]   rem_ext;
   logic [SHAMT_W:0]   k_ext;
   logic [SHAMT_W-1:0] k;
   logic [WIDTH-1:0]   shift_res;

   // step size this cycle: min(STEP, rem)
   always_comb begin
      rem_ext = {1'b0, rem_q};
      k_ext   = (rem_ext < STEP_C) ? rem_ext : STEP_C;
      k       = k_ext[SHAMT_W-1:0];
   end

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
   logic [SHAMT_W:0] rot_rsh;
   logic [WIDTH-1:0] rot_res;

   // rotate left; k is never 0 in SHIFT so rot_rsh < WIDTH
   always_comb begin
      rot_rsh = WIDTH_C - k_ext;
      rot_res = (data_q << k) | (data_q >> rot_rsh);
   end
`else
   logic unused_width;
   assign unused_width = ^WIDTH_C;
`endif

   // one partial shift of the working register by k
   always_comb begin
      shift_res = data_q;
      case (op_q)
         OP_SLL: shift_res = data_q << k;
         OP_SRL: shift_res = data_q >> k;
         OP_SRA: shift_res = WIDTH'($signed(data_q) >>> k);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
         OP_ROL: shift_res = rot_res;
`else
         OP_ROL: shift_res = data_q << k;
`endif
         default: shift_res = data_q;
      endcase
   end

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               data_d  = data_i;
               op_d    = op_i;
               rem_d   = shamt_i;
               state_d = (shamt_i != '0) ? SHIFT : DONE;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            data_d  = shift_res;
            rem_d   = rem_q - k;
            state_d = (rem_q == k) ? DONE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and working registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         op_q    <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
      end
   end

   assign data_o = data_q;
   assign busy_o = (state_q == SHIFT);
   assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: STEP=1 and STEP=4 instances vs a
// per-cycle behavioural model plus directed literal checks.
module tb_iterative_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] din;
   logic [4:0]  sh;

   logic [31:0] dout0, dout1;
   logic        busy0, busy1, done0, done1;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
      .data_i(din), .shamt_i(sh),
      .data_o(dout0), .busy_o(busy0), .done_o(done0)
   );

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
      .data_i(din), .shamt_i(sh),
      .data_o(dout1), .busy_o(busy1), .done_o(done1)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_f(logic [1:0] o, logic [31:0] d,
                                         int s);
      logic [63:0] t;
      t = {d, d} << s;
      case (o)
         2'b00: return d << s;
         2'b01: return d >> s;
         2'b10: return 32'($signed(d) >>> s);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
         default: return t[63:32];
`else
         default: return d << s;
`endif
      endcase
   endfunction

   // model: remaining busy cycles, done flag, final result
   int          m_cnt  [2];
   bit          m_done [2];
   logic [31:0] m_res  [2];
   int          steps  [2] = '{1, 4};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
            m_res[i]  = '0;
         end else if (m_cnt[i] == 0) begin
            m_done[i] = 1'b0;
            if (start) begin
               m_res[i] = ref_f(op, din, int'(sh));
               m_cnt[i] = (int'(sh) + steps[i] - 1) / steps[i];
               m_done[i] = (m_cnt[i] == 0);
            end
         end else begin
            m_cnt[i]--;
            m_done[i] = (m_cnt[i] == 0);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_busy1", {31'd0, busy0}, {31'd0, m_cnt[0] > 0});
         chk("m_done1", {31'd0, done0}, {31'd0, m_done[0]});
         if (m_cnt[0] == 0) chk("m_data1", dout0, m_res[0]);
         chk("m_busy4", {31'd0, busy1}, {31'd0, m_cnt[1] > 0});
         chk("m_done4", {31'd0, done1}, {31'd0, m_done[1]});
         if (m_cnt[1] == 0) chk("m_data4", dout1, m_res[1]);
      end
   end

   // pulse start for one cycle from a negedge; returns at next negedge
   task automatic go(logic [1:0] o, logic [31:0] d, logic [4:0] s);
      start = 1'b1;
      op    = o;
      din   = d;
      sh    = s;
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      din   = $urandom;
      sh    = 5'($urandom);
   endtask

   // wait for done of instance idx; c0 = cycles already elapsed
   task automatic wait_done(int idx, int c0, int exp_c,
                            logic [31:0] exp_d, string name);
      int c;
      c = c0;
      while (!(idx == 0 ? done0 : done1) && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk({name, "_lat"}, c, exp_c);
      chk({name, "_res"}, idx == 0 ? dout0 : dout1, exp_d);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while ((busy0 || busy1 || done0 || done1) && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("idle_timeout", {31'd0, c >= 200}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      din   = '0;
      sh    = '0;
      repeat (2) @(negedge clk);
      chk("rst_data", dout0, 32'h0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      go(2'b00, 32'h0000_0001, 5'd2);
      chk("sll_busy", {31'd0, busy0}, 32'd1);
      wait_done(0, 1, 3, 32'h0000_0004, "sll2");
      wait_idle();

      go(2'b10, 32'h8000_00F0, 5'd4);
      wait_done(1, 1, 2, 32'hF800_000F, "sra4_s4");
      wait_idle();
      go(2'b01, 32'h8000_00F0, 5'd4);
      wait_done(1, 1, 2, 32'h0800_000F, "srl4_s4");
      wait_idle();
      go(2'b10, 32'h8000_00F0, 5'd4);
      wait_done(0, 1, 5, 32'hF800_000F, "sra4_s1");
      wait_idle();

      go(2'b10, 32'hDEAD_BEEF, 5'd0);
      chk("sh0_busy", {31'd0, busy0}, 32'd0);
      wait_done(0, 1, 1, 32'hDEAD_BEEF, "sh0");
      wait_idle();

      go(2'b00, 32'h0000_0001, 5'd8);
      @(negedge clk);
      go(2'b00, 32'hFFFF_FFFF, 5'd3);
      wait_done(0, 3, 9, 32'h0000_0100, "ignore");
      go(2'b01, 32'h0000_00F0, 5'd4);
      chk("b2b_done", {31'd0, done0}, 32'd0);
      chk("b2b_busy", {31'd0, busy0}, 32'd1);
      wait_done(0, 1, 5, 32'h0000_000F, "b2b");
      wait_idle();

      go(2'b00, 32'h0000_1234, 5'd10);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_data", dout0, 32'h0);
      chk("abort_busy", {31'd0, busy0}, 32'd0);
      chk("abort_done", {31'd0, done0}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_nodone", {31'd0, done0}, 32'd0);
      end
      go(2'b00, 32'h0000_0001, 5'd2);
      wait_done(0, 1, 3, 32'h0000_0004, "post_rst");
      wait_idle();

      go(2'b11, 32'h8000_0001, 5'd1);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      wait_done(0, 1, 2, 32'h0000_0003, "rol");
`else
      wait_done(0, 1, 2, 32'h0000_0002, "op11");
`endif
      wait_idle();

      go(2'b00, 32'h0000_0001, 5'd31);
      wait_done(0, 1, 32, 32'h8000_0000, "sll31");
      wait_idle();
      go(2'b10, 32'h8000_0000, 5'd31);
      wait_done(1, 1, 9, 32'hFFFF_FFFF, "sra31_s4");
      wait_idle();

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle, parametrised shift unit for the MIPS datapath, serving variable-amount SLL/SRL/SRA (and optional rotate) instructions that the fixed-amount branch-offset shifter cannot handle. It latches an operand, opcode and shift amount on a start pulse, then shifts STEP bits per cycle until done, trading latency for area. It sits beside the ALU and is stalled on by the control unit via busy_o/done_o.

## Interface
- WIDTH, 32: operand/result width in bits.
- SHAMT_W, 5: shift-amount width; must equal clog2(WIDTH).
- STEP, 1: bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.

- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only when busy_o = 0.
- op_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
- data_i  input  WIDTH  operand.
- shamt_i  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- data_o  output  WIDTH  result register.
- busy_o  output  1  high while in SHIFT.
- done_o  output  1  one-cycle pulse, result valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE with start_i=1: latch data_i into working register, op_i, rem ← shamt_i. Next state SHIFT if shamt_i ≠ 0, else DONE.
- IDLE/DONE with start_i=0: DONE → IDLE; IDLE holds.
- SHIFT, each edge: k = min(STEP, rem); working register shifted by k; rem ← rem − k; next state DONE when rem − k = 0, else SHIFT.
- Fill rules: SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates bit WIDTH-1 of the current working value; ROL moves bits shifted out of MSB into LSB.
- data_o is the working register; holds final result until the next accepted start; not meaningful during SHIFT.
- start_i while busy_o=1: ignored; no queuing, operands not resampled.
- op_i, data_i, shamt_i are don't-care except in the accepting cycle.

## Timing
- Reset (rst_i=1 at an edge): state IDLE, data_o = 0, busy_o = 0, done_o = 0, rem = 0. Applies mid-operation: operation aborted, no done_o pulse.
- Latency: n = ceil(shamt/STEP); done_o high in the cycle n+1 edges after the accepting edge. shamt=0 → done_o next cycle, data_o = data_i.
- WIDTH=32, STEP=1, shamt=31 → done 32 cycles after start.
- busy_o high exactly n cycles; done_o high exactly 1 cycle; busy_o and done_o never high together.
- Back-to-back: start_i asserted in the DONE cycle is accepted; done_o then drops next cycle, busy_o rises (or done_o re-pulses if new shamt=0).
- All outputs registered; no combinational path input → output.

## Configuration
- ITERATIVE_SHIFTER_ROTATE_EN defined: op_i=11 performs rotate-left by shamt.
- Not defined: op_i=11 decoded as SLL; rotate logic absent.

## Test plan
- STEP=1: start, SLL, data 32'h0000_0001, shamt 2 → done_o 3 cycles after start, data_o 32'h0000_0004, busy_o high 2 cycles.
- SRA vs SRL, data 32'h8000_00F0, shamt 4 → SRA 32'hF800_000F, SRL 32'h0800_000F; with STEP=4 both done 2 cycles after start.
- shamt 0, data 32'hDEAD_BEEF, any op → done_o next cycle, data_o 32'hDEAD_BEEF, busy_o never high.
- SLL shamt 8 started; start_i with data 32'hFFFF_FFFF pulsed mid-SHIFT → ignored, original result delivered; start in DONE cycle accepted immediately.
- rst_i asserted 3 cycles into shamt 10 shift → next cycle data_o 0, busy_o 0, no done_o pulse; fresh start afterwards completes normally.
- op 11, data 32'h8000_0001, shamt 1 → with ITERATIVE_SHIFTER_ROTATE_EN 32'h0000_0003; without 32'h0000_0002.
